// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: single-outstanding request/acknowledge bus.
//
// Used both for the master-side ports (CPU, loader) and for the DRAM
// command port of mem_arbiter.
//   req   : request level (masters) / one-cycle command strobe (DRAM side)
//   we    : byte write enables, 0 = read
//   addr  : byte address
//   wdata : write data
//   ack   : one-cycle completion
//   rdata : read data, valid with ack
// Modports:
//   master : drives req/we/addr/wdata, receives ack/rdata
//   slave  : receives req/we/addr/wdata, drives ack/rdata
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic [3:0]    we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (output req, output we, output addr, output wdata,
                  input  ack, input  rdata);
  modport slave  (input  req, input  we, input  addr, input  wdata,
                  output ack, output rdata);
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master, one-slave round-robin arbiter for the shared
// DRAM data port. Master 0 is the CPU data port, master 1 the program
// loader. One transaction is outstanding at a time; each one is
// IDLE -> ISSUE (one-cycle command strobe) -> WAIT (for DRAM ready) ->
// ACK (one-cycle ack to the owning master) -> IDLE.
//
// Ports:
//   clk   : system clock
//   rst   : synchronous active-high reset (aborts any transaction)
//   m0    : CPU bus (slave modport; req/we/addr/wdata in, ack/rdata out)
//   m1    : loader bus (same as m0)
//   s     : DRAM command bus (master modport): s.req is the one-cycle
//           command strobe, s.ack the one-cycle DRAM ready
//   grant : one-hot current owner, 0 when idle
//   err   : sticky timeout flag
//
// Optional feature: define MEM_ARBITER_TIMEOUT_EN to abort a WAIT that
// lasts TIMEOUT cycles; the owner is then acked with 32'hdeadbeef and
// err is set until reset. Without it WAIT is unbounded and err is 0.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  m0,
  mem_arbiter_if.slave  m1,
  mem_arbiter_if.master s,
  output logic [1:0]    grant,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;

  logic          last_m1;     // 1 when m1 was served last
  logic          any_req;
  logic          pick_m1;     // winner of the IDLE arbitration
  logic          timeout_hit;
  logic [DW-1:0] resp_data;

  logic [3:0]    cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;

  // m1 wins when it is the only requester, or on a tie when m0 was
  // served last. Reset leaves last_m1 = 1 so m0 wins the first tie.
  always_comb begin
    any_req    = m0.req | m1.req;
    pick_m1    = m1.req & (~m0.req | ~last_m1);
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (s.ack || timeout_hit) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A ready from DRAM takes precedence over a timeout in the same cycle.
  assign resp_data = s.ack ? s.rdata : DW'(32'hdeadbeef);

  // Command capture, owner tracking and response latching. Every output
  // is cleared on reset, so the command and read-data registers are
  // reset as well.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_m1   <= 1'b1;
      grant     <= 2'b00;
      cmd_we    <= '0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant     <= pick_m1 ? 2'b10 : 2'b01;
            last_m1   <= pick_m1;
            cmd_we    <= pick_m1 ? m1.we    : m0.we;
            cmd_addr  <= pick_m1 ? m1.addr  : m0.addr;
            cmd_wdata <= pick_m1 ? m1.wdata : m0.wdata;
          end
        end
        WAIT: begin
          // Only the owner's read-data register changes; the other
          // master keeps seeing its previous value.
          if (s.ack || timeout_hit) begin
            if (grant[1]) rdata1 <= resp_data;
            else          rdata0 <= resp_data;
          end
        end
        ACK:     grant <= 2'b00;
        default: ;
      endcase
    end
  end

  assign s.req    = (state == ISSUE);
  assign s.we     = cmd_we;
  assign s.addr   = cmd_addr;
  assign s.wdata  = cmd_wdata;

  assign m0.ack   = (state == ACK) & grant[0];
  assign m1.ack   = (state == ACK) & grant[1];
  assign m0.rdata = rdata0;
  assign m1.rdata = rdata1;

`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;

  logic [CW-1:0] wait_cnt;
  logic          err_q;

  // wait_cnt is 0 on the first WAIT cycle and counts WAIT cycles without
  // ready; the abort fires in the cycle the count would reach TIMEOUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state != WAIT) wait_cnt <= '0;
      else if (!s.ack)   wait_cnt <= wait_cnt + CW'(1);
      if (timeout_hit)   err_q <= 1'b1;
    end
  end

  assign timeout_hit = (state == WAIT) && !s.ack && (wait_cnt == CW'(TIMEOUT - 1));
  assign err         = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: bench for mem_arbiter. A transaction-level model
// (time-stamped owner / issue cycle / ack cycle) predicts grant, strobe,
// acks, read data and err from the bench-driven inputs, and one negedge
// process compares every cycle. Directed scenarios add literal checks;
// a randomized phase follows with a reactive DRAM responder.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] grant;
  logic       err;

  mem_arbiter_if #(.AW(AW), .DW(DW)) m0_bus ();
  mem_arbiter_if #(.AW(AW), .DW(DW)) m1_bus ();
  mem_arbiter_if #(.AW(AW), .DW(DW)) s_bus ();

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst   (rst),
    .m0    (m0_bus),
    .m1    (m1_bus),
    .s     (s_bus),
    .grant (grant),
    .err   (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- DRAM responder ----------------
  bit          dram_mute  = 1'b0;
  bit          dram_rand  = 1'b0;
  bit          dram_spur  = 1'b0;
  int          dram_delay = 2;
  logic [31:0] dram_data  = 32'h12345678;

  initial begin : dram
    bit pend;
    int cnt;
    bit oe_seen;
    bit rst_seen;
    pend = 1'b0;
    cnt  = 0;
    s_bus.ack   = 1'b0;
    s_bus.rdata = '0;
    forever begin
      @(negedge clk);
      oe_seen  = (s_bus.req === 1'b1);
      rst_seen = rst;
      @(posedge clk);
      #1;
      s_bus.ack   = 1'b0;
      s_bus.rdata = $urandom;
      if (rst_seen) pend = 1'b0;
      else if (oe_seen) begin
        pend = 1'b1;
        cnt  = dram_rand ? int'($urandom_range(1, 8)) : dram_delay;
      end
      if (pend && !dram_mute) begin
        cnt--;
        if (cnt == 0) begin
          pend      = 1'b0;
          s_bus.ack = 1'b1;
          if (!dram_rand) s_bus.rdata = dram_data;
        end
      end else if (!pend && dram_spur && $urandom_range(0, 4) == 0) begin
        s_bus.ack = 1'b1;
      end
    end
  end

  // ---------------- transaction-level model + compare ----------------
  bit          m_valid = 1'b0;
  bit          m_busy  = 1'b0;
  bit          m_last  = 1'b1;
  bit          m_after_rst = 1'b0;
  bit          m_err   = 1'b0;
  int          m_owner = 0;
  int          m_issue = 0;
  int          m_ack   = -1;
  logic [31:0] m_rd [2];
  logic [3:0]  m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;

  always @(negedge clk) begin : model
    logic [1:0] eg;
    bit         eo;
    int         w;
    if (m_valid) begin
      eg = m_busy ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
      eo = m_busy && (cyc == m_issue);
      check("grant",    64'(grant),          64'(eg));
      check("s_oe",     64'(s_bus.req),      64'(eo));
      check("m0_ack",   64'(m0_bus.ack),     64'(m_busy && cyc == m_ack && m_owner == 0));
      check("m1_ack",   64'(m1_bus.ack),     64'(m_busy && cyc == m_ack && m_owner == 1));
      check("m0_rdata", 64'(m0_bus.rdata),   64'(m_rd[0]));
      check("m1_rdata", 64'(m1_bus.rdata),   64'(m_rd[1]));
      check("err",      64'(err),            64'(m_err));
      if (eo) begin
        check("s_we",    64'(s_bus.we),    64'(m_we));
        check("s_addr",  64'(s_bus.addr),  64'(m_addr));
        check("s_wdata", 64'(s_bus.wdata), 64'(m_wdata));
      end
      if (m_after_rst) begin
        check("s_we_rst",    64'(s_bus.we),    64'd0);
        check("s_addr_rst",  64'(s_bus.addr),  64'd0);
        check("s_wdata_rst", 64'(s_bus.wdata), 64'd0);
      end
    end
    // advance using this cycle's inputs
    if (rst) begin
      m_valid     = 1'b1;
      m_busy      = 1'b0;
      m_last      = 1'b1;
      m_err       = 1'b0;
      m_rd[0]     = '0;
      m_rd[1]     = '0;
      m_after_rst = 1'b1;
    end else begin
      m_after_rst = 1'b0;
      if (m_busy) begin
        if (m_ack >= 0 && cyc == m_ack) m_busy = 1'b0;
        else if (m_ack < 0 && cyc > m_issue) begin
          if (s_bus.ack === 1'b1) begin
            m_ack         = cyc + 1;
            m_rd[m_owner] = s_bus.rdata;
          end
`ifdef MEM_ARBITER_TIMEOUT_EN
          else if (cyc - m_issue == TO) begin
            m_ack         = cyc + 1;
            m_rd[m_owner] = 32'hdeadbeef;
            m_err         = 1'b1;
          end
`endif
        end
      end else if (m0_bus.req === 1'b1 || m1_bus.req === 1'b1) begin
        if (m0_bus.req === 1'b1 && m1_bus.req === 1'b1) w = m_last ? 0 : 1;
        else w = (m1_bus.req === 1'b1) ? 1 : 0;
        m_busy  = 1'b1;
        m_owner = w;
        m_last  = (w == 1);
        m_issue = cyc + 1;
        m_ack   = -1;
        m_we    = w ? m1_bus.we    : m0_bus.we;
        m_addr  = w ? m1_bus.addr  : m0_bus.addr;
        m_wdata = w ? m1_bus.wdata : m0_bus.wdata;
      end
    end
  end

  // ---------------- helpers for directed scenarios ----------------
  task automatic wait_oe(input int maxc, output int at);
    at = -1;
    for (int n = 0; n < maxc; n++) begin
      @(negedge clk);
      if (s_bus.req === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_any_ack(input int maxc, output int who, output int at);
    who = -1;
    at  = -1;
    for (int n = 0; n < maxc; n++) begin
      @(negedge clk);
      if (m0_bus.ack === 1'b1 || m1_bus.ack === 1'b1) begin
        who = (m0_bus.ack === 1'b1) ? 0 : 1;
        at  = cyc;
        break;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_grant"}, 64'(grant),        64'd0);
    check({tag, "_s_oe"},  64'(s_bus.req),    64'd0);
    check({tag, "_s_we"},  64'(s_bus.we),     64'd0);
    check({tag, "_s_adr"}, 64'(s_bus.addr),   64'd0);
    check({tag, "_s_wd"},  64'(s_bus.wdata),  64'd0);
    check({tag, "_ack0"},  64'(m0_bus.ack),   64'd0);
    check({tag, "_ack1"},  64'(m1_bus.ack),   64'd0);
    check({tag, "_rd0"},   64'(m0_bus.rdata), 64'd0);
    check({tag, "_rd1"},   64'(m1_bus.rdata), 64'd0);
    check({tag, "_err"},   64'(err),          64'd0);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int k;
    int at;
    int who;
    bit a0;
    bit a1;
    int exp_who [4];
    logic [1:0] exp_gnt [4];

    m0_bus.req = 1'b0; m0_bus.we = '0; m0_bus.addr = '0; m0_bus.wdata = '0;
    m1_bus.req = 1'b0; m1_bus.we = '0; m1_bus.addr = '0; m1_bus.wdata = '0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check_zero("reset");

    // m0 read 0x100, DRAM answers 2 cycles after the strobe
    tick();
    m0_bus.req = 1'b1; m0_bus.we = 4'b0000; m0_bus.addr = 32'h100; m0_bus.wdata = $urandom;
    k = cyc;
    wait_oe(10, at);
    check("t1_oe_cycle", 64'(at - k), 64'd1);
    check("t1_s_addr",   64'(s_bus.addr), 64'h100);
    check("t1_s_we",     64'(s_bus.we),   64'd0);
    wait_any_ack(20, who, at);
    check("t1_who",      64'(who), 64'd0);
    check("t1_latency",  64'(at - k), 64'd4);
    check("t1_rdata",    64'(m0_bus.rdata), 64'h12345678);
    check("t1_grant",    64'(grant), 64'b01);
    tick();
    m0_bus.req = 1'b0;

    // m1 partial write
    tick();
    m1_bus.req = 1'b1; m1_bus.we = 4'b0011; m1_bus.addr = 32'h2000; m1_bus.wdata = 32'haabbccdd;
    k = cyc;
    wait_oe(10, at);
    check("t2_s_we",    64'(s_bus.we),    64'b0011);
    check("t2_s_addr",  64'(s_bus.addr),  64'h2000);
    check("t2_s_wdata", 64'(s_bus.wdata), 64'haabbccdd);
    wait_any_ack(20, who, at);
    check("t2_who",     64'(who), 64'd1);
    check("t2_latency", 64'(at - k), 64'd4);
    check("t2_err",     64'(err), 64'd0);
    tick();
    m1_bus.req = 1'b0;

    // both request right after reset and stay asserted: m0, m1, m0, m1
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m0_bus.req = 1'b1; m0_bus.we = 4'b0000; m0_bus.addr = 32'h300;  m0_bus.wdata = '0;
    m1_bus.req = 1'b1; m1_bus.we = 4'b1111; m1_bus.addr = 32'h3000; m1_bus.wdata = 32'h55aa55aa;
    exp_who = '{0, 1, 0, 1};
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
    for (int i = 0; i < 4; i++) begin
      wait_any_ack(20, who, at);
      check($sformatf("t3_order%0d", i), 64'(who),   64'(exp_who[i]));
      check($sformatf("t3_grant%0d", i), 64'(grant), 64'(exp_gnt[i]));
    end
    tick();
    m0_bus.req = 1'b0;
    m1_bus.req = 1'b0;

    // m1 streams; m0 raises once mid-transaction and is served next
    tick();
    m1_bus.req = 1'b1; m1_bus.we = 4'b0000; m1_bus.addr = 32'h4000;
    wait_any_ack(20, who, at);
    check("t4_first_m1", 64'(who), 64'd1);
    wait_oe(10, at);
    tick();
    m0_bus.req = 1'b1; m0_bus.we = 4'b0000; m0_bus.addr = 32'h444;
    wait_any_ack(20, who, at);
    check("t4_inflight_m1", 64'(who), 64'd1);
    wait_any_ack(20, who, at);
    check("t4_m0_served", 64'(who), 64'd0);
    tick();
    m0_bus.req = 1'b0;
    m1_bus.req = 1'b0;

    // reset while waiting on a DRAM that never answers
    dram_mute = 1'b1;
    tick();
    m0_bus.req = 1'b1; m0_bus.we = 4'b0000; m0_bus.addr = 32'h40;
    k = cyc;
    wait_oe(10, at);
    check("t5_oe_cycle", 64'(at - k), 64'd1);
    tick();
    tick();
    rst = 1'b1;
    m0_bus.req = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_zero("t5");
    dram_mute  = 1'b0;
    dram_delay = 1;
    dram_data  = 32'hcafef00d;
    tick();
    m0_bus.req = 1'b1; m0_bus.addr = 32'h80;
    k = cyc;
    wait_any_ack(20, who, at);
    check("t5_who",     64'(who), 64'd0);
    check("t5_latency", 64'(at - k), 64'd3);
    check("t5_rdata",   64'(m0_bus.rdata), 64'hcafef00d);
    tick();
    m0_bus.req = 1'b0;

`ifdef MEM_ARBITER_TIMEOUT_EN
    // timeout abort with TIMEOUT = 8, then a normal transaction
    dram_mute = 1'b1;
    tick();
    m0_bus.req = 1'b1; m0_bus.we = 4'b0000; m0_bus.addr = 32'h500;
    k = cyc;
    wait_any_ack(40, who, at);
    check("t6_who",     64'(who), 64'd0);
    check("t6_latency", 64'(at - k), 64'd10);
    check("t6_rdata",   64'(m0_bus.rdata), 64'hdeadbeef);
    check("t6_err",     64'(err), 64'd1);
    tick();
    m0_bus.req = 1'b0;
    dram_mute  = 1'b0;
    dram_delay = 2;
    dram_data  = 32'h01020304;
    tick();
    m1_bus.req = 1'b1; m1_bus.we = 4'b0000; m1_bus.addr = 32'h600;
    k = cyc;
    wait_any_ack(20, who, at);
    check("t6b_who",     64'(who), 64'd1);
    check("t6b_latency", 64'(at - k), 64'd4);
    check("t6b_rdata",   64'(m1_bus.rdata), 64'h01020304);
    check("t6b_err",     64'(err), 64'd1);
    tick();
    m1_bus.req = 1'b0;
`endif

    // randomized traffic with reactive masters and spurious DRAM readies
    dram_rand = 1'b1;
    dram_spur = 1'b1;
    a0 = 1'b0;
    a1 = 1'b0;
    for (int n = 0; n < 2500; n++) begin
      tick();
      if (m0_bus.req) begin
        if (a0 && $urandom_range(0, 3) != 0) m0_bus.req = 1'b0;
        else if (a0 || $urandom_range(0, 3) == 0) begin
          m0_bus.we    = $urandom_range(0, 1) ? 4'($urandom) : 4'b0000;
          m0_bus.addr  = $urandom;
          m0_bus.wdata = $urandom;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        m0_bus.req   = 1'b1;
        m0_bus.we    = $urandom_range(0, 1) ? 4'($urandom) : 4'b0000;
        m0_bus.addr  = $urandom;
        m0_bus.wdata = $urandom;
      end
      if (m1_bus.req) begin
        if (a1 && $urandom_range(0, 3) != 0) m1_bus.req = 1'b0;
        else if (a1 || $urandom_range(0, 3) == 0) begin
          m1_bus.we    = $urandom_range(0, 1) ? 4'($urandom) : 4'b0000;
          m1_bus.addr  = $urandom;
          m1_bus.wdata = $urandom;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        m1_bus.req   = 1'b1;
        m1_bus.we    = $urandom_range(0, 1) ? 4'($urandom) : 4'b0000;
        m1_bus.addr  = $urandom;
        m1_bus.wdata = $urandom;
      end
      @(negedge clk);
      a0 = (m0_bus.ack === 1'b1);
      a1 = (m1_bus.ack === 1'b1);
    end
    tick();
    m0_bus.req = 1'b0;
    m1_bus.req = 1'b0;
    dram_spur  = 1'b0;
    repeat (40) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
